// File: rtl/op_buffer_drain_ctrl.sv
// op_buffer_drain_ctrl: stages systolic-array result rows in a small row FIFO
// and serializes them into one-word-per-cycle store commands for the output
// buffer. One drain pass writes NUM_ROWS*LANES consecutive entries from
// address 0, then pulses drain_done.
// Optional feature macro: OP_DRAIN_RELU_EN (clamp negative words to 0 at
// serialization time).
module op_buffer_drain_ctrl #(
  parameter int DATA_W     = 32,
  parameter int LANES      = 4,
  parameter int NUM_ROWS   = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      drain_start,
  input  logic                      array_res_valid,
  input  logic [LANES*DATA_W-1:0]   array_res_data,
  output logic                      array_res_ready,
  output logic [DATA_W-1:0]         data,
  output logic [ADDR_W-1:0]         op_buf_addr_for_store,
  output logic                      op_buffer_instr_for_storing_data,
  output logic                      drain_busy,
  output logic                      drain_done
);

  localparam int TOTAL  = NUM_ROWS * LANES;
  localparam int WW_W   = $clog2(TOTAL + 1);
  localparam int ROW_W  = $clog2(NUM_ROWS + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                    state;
  logic [ROW_W-1:0]          accepted_rows;
  logic [LANE_W-1:0]         lane;
  logic [WW_W-1:0]           words_written;

  logic [LANES*DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full, fifo_empty;
  logic                      push, pop, issue;
  logic [DATA_W-1:0]         head_word, out_word;

  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  // Ready depends only on registered state, never on a same-cycle pop.
  assign array_res_ready = (state == DRAIN) && !fifo_full &&
                           (accepted_rows < ROW_W'(NUM_ROWS));
  assign push  = array_res_valid && array_res_ready;
  assign issue = (state == DRAIN) && !fifo_empty;
  assign pop   = issue && (lane == LANE_W'(LANES - 1));

  // Select the current lane of the head row and apply the optional clamp.
  always_comb begin
    head_word = mem[rd_ptr][lane*DATA_W +: DATA_W];
    out_word  = head_word;
`ifdef OP_DRAIN_RELU_EN
    if (head_word[DATA_W-1]) out_word = '0;
`else
`endif
  end

  // Row storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= array_res_data;
  end

  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Drain FSM with the serializer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                            <= IDLE;
      accepted_rows                    <= '0;
      lane                             <= '0;
      words_written                    <= '0;
      data                             <= '0;
      op_buf_addr_for_store            <= '0;
      op_buffer_instr_for_storing_data <= 1'b0;
      drain_busy                       <= 1'b0;
      drain_done                       <= 1'b0;
    end else begin
      op_buffer_instr_for_storing_data <= 1'b0;
      drain_done                       <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_start) begin
            state         <= DRAIN;
            drain_busy    <= 1'b1;
            accepted_rows <= '0;
            lane          <= '0;
            words_written <= '0;
          end
        end
        DRAIN: begin
          if (push) accepted_rows <= accepted_rows + ROW_W'(1);
          if (issue) begin
            data                             <= out_word;
            op_buf_addr_for_store            <= ADDR_W'(words_written);
            op_buffer_instr_for_storing_data <= 1'b1;
            words_written                    <= words_written + WW_W'(1);
            lane                             <= pop ? '0 : lane + LANE_W'(1);
          end
          // The counter reaches TOTAL as the last strobe becomes visible, so
          // done lands on the cycle after that strobe.
          if (words_written == WW_W'(TOTAL)) begin
            state      <= DONE;
            drain_busy <= 1'b0;
            drain_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          drain_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_buffer_drain_ctrl.sv
// Self-checking bench for op_buffer_drain_ctrl: a queue-based timing model
// predicts every store word and the busy/done phases, plus directed literal
// checks per scenario.
module tb_op_buffer_drain_ctrl;
  localparam int DW = 32, L = 4, NR = 4, FD = 2, AW = 4, TOT = NR * L;

  logic clk = 1'b0;
  logic rst, drain_start, valid;
  logic [L*DW-1:0] rdata;
  logic ready, stb, busy, done;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;

  op_buffer_drain_ctrl #(.DATA_W(DW), .LANES(L), .NUM_ROWS(NR),
                         .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .drain_start(drain_start),
    .array_res_valid(valid), .array_res_data(rdata),
    .array_res_ready(ready), .data(data), .op_buf_addr_for_store(addr),
    .op_buffer_instr_for_storing_data(stb), .drain_busy(busy),
    .drain_done(done));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef OP_DRAIN_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // ---------------- model ----------------
  typedef struct { int t; logic [AW-1:0] a; logic [DW-1:0] d; } wd_t;
  typedef enum {M_IDLE, M_DRAIN, M_DONE} mph_t;
  wd_t  q[$];
  mph_t ph = M_IDLE;
  int n = 0, acc = 0, last_t = -100, done_cyc = 0, start_cyc = 0;
  int pass_strobes = 0, first_stb = 0, last_stb = 0, done_seen = 0, done_at = 0;
  bit exp_zero = 0;
  logic [DW-1:0] cap_d [TOT];
  logic [AW-1:0] cap_a [TOT];

  always @(posedge clk) n++;

  // Compare outputs of the cycle just completed, then advance the model.
  always @(negedge clk) begin
    bit exp_stb;
    wd_t w;
    int t;
    if (exp_zero) begin
      chk("rst_data", data, 0);
      chk("rst_addr", addr, 0);
      exp_zero = 0;
    end
    chk("busy", busy, ph == M_DRAIN);
    chk("done", done, ph == M_DONE);
    if (ph != M_DRAIN || acc >= NR) chk("ready_low", ready, 0);
    exp_stb = (q.size() > 0) && (q[0].t == n);
    chk("strobe", stb, exp_stb);
    if (stb) begin
      if (exp_stb) begin
        chk("addr", addr, q[0].a);
        chk("data", data, q[0].d);
        void'(q.pop_front());
      end
      if (pass_strobes < TOT) begin
        cap_a[pass_strobes] = addr;
        cap_d[pass_strobes] = data;
      end
      if (pass_strobes == 0) first_stb = n;
      last_stb = n;
      pass_strobes++;
    end
    if (done) begin
      done_seen++;
      done_at = n;
    end
    if (rst) begin
      q.delete();
      ph = M_IDLE;
      acc = 0;
      exp_zero = 1;
    end else begin
      if (valid && ready) begin
        // Row lanes stream back to back, no earlier than 2 cycles after offer.
        for (int k = 0; k < L; k++) begin
          t = (last_t + 1 > n + 2) ? last_t + 1 : n + 2;
          w.t = t;
          w.a = AW'(acc * L + k);
          w.d = relu(rdata[k*DW +: DW]);
          q.push_back(w);
          last_t = t;
        end
        acc++;
        if (acc == NR) done_cyc = last_t + 1;
      end
      case (ph)
        M_DRAIN: if (acc == NR && n + 1 == done_cyc) ph = M_DONE;
        M_DONE:  ph = M_IDLE;
        default: if (drain_start) begin
          ph = M_DRAIN; acc = 0; last_t = -100; start_cyc = n + 1; pass_strobes = 0;
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  logic [L*DW-1:0] rows [8];
  bit abort = 0;

  task automatic pulse_start();
    @(posedge clk); #1 drain_start = 1;
    @(posedge clk); #1 drain_start = 0;
  endtask

  task automatic send(input int nrows, input int gap, input int budget, output int sent);
    int waited;
    bit acc_now;
    sent = 0; waited = 0;
    while (sent < nrows && !abort && waited < budget) begin
      valid = 1; rdata = rows[sent];
      @(negedge clk); acc_now = ready;
      @(posedge clk); #1;
      waited++;
      if (acc_now) begin
        sent++;
        valid = 0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    valid = 0;
  endtask

  task automatic wait_done(input int d0);
    int w;
    w = 0;
    while (done_seen == d0 && w < 200) begin @(posedge clk); #1; w++; end
    chk("done_arrived", done_seen > d0, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_strobes(input int cnt);
    int w;
    w = 0;
    while (pass_strobes < cnt && w < 200) begin @(posedge clk); #1; w++; end
    chk("strobe_wait", pass_strobes >= cnt, 1);
  endtask

  task automatic fill_rows();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < L; k++) rows[r][k*DW +: DW] = 32'h100 * r + k;
  endtask

  initial begin
    int sent, d0;
    rst = 1; drain_start = 0; valid = 0; rdata = '0;
    fill_rows();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("reset_stb", stb, 0);
    chk("reset_data", data, 0);
    chk("reset_addr", addr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", ready, 0);

    // Basic pass with valid held high; a 5th row is offered but never taken.
    d0 = done_seen;
    pulse_start();
    send(5, 0, 60, sent);
    wait_done(d0);
    chk("bp_rows_taken", sent, 4);
    chk("basic_count", pass_strobes, 16);
    chk("basic_latency", first_stb - start_cyc, 2);
    chk("bp_contiguous", last_stb - first_stb, 15);
    chk("basic_done_after", done_at - last_stb, 1);
    chk("basic_done_once", done_seen - d0, 1);
    chk("basic_d15", cap_d[15], 32'h303);
    chk("basic_d6", cap_d[6], 32'h102);
    chk("basic_a9", cap_a[9], 9);

    // Row offered in IDLE is refused; drain_start during the pass is ignored.
    valid = 1; rdata = rows[0];
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_ready", ready, 0);
    chk("idle_stb", stb, 0);
    valid = 0;
    d0 = done_seen;
    pulse_start();
    fork
      send(4, 0, 60, sent);
      begin
        wait_strobes(4);
        drain_start = 1;
        @(posedge clk); #1 drain_start = 0;
      end
    join
    wait_done(d0);
    chk("ign_count", pass_strobes, 16);
    chk("ign_a5", cap_a[5], 5);
    chk("ign_a15", cap_a[15], 15);
    chk("ign_done_once", done_seen - d0, 1);

    // Reset in the middle of a pass, then a fresh pass from address 0.
    pulse_start();
    fork
      send(4, 0, 60, sent);
      begin
        wait_strobes(6);
        rst = 1; abort = 1;
        @(posedge clk); #1 rst = 0;
      end
    join
    chk("mid_rst_stb", stb, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_busy", busy, 0);
    abort = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_rst_quiet", stb, 0);
    d0 = done_seen;
    pulse_start();
    send(4, 0, 60, sent);
    wait_done(d0);
    chk("restart_a0", cap_a[0], 0);
    chk("restart_d0", cap_d[0], 0);
    chk("restart_count", pass_strobes, 16);

    // Gapped source: one row every 10 cycles.
    d0 = done_seen;
    pulse_start();
    send(4, 9, 200, sent);
    wait_done(d0);
    chk("gap_count", pass_strobes, 16);
    chk("gap_span", last_stb - first_stb, 33);
    chk("gap_done_after", done_at - last_stb, 1);

    // Sign-bit handling of a row with negative and boundary values.
    rows[0] = {32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    d0 = done_seen;
    pulse_start();
    send(4, 0, 60, sent);
    wait_done(d0);
`ifdef OP_DRAIN_RELU_EN
    chk("relu_l0", cap_d[0], 32'h0);
    chk("relu_l1", cap_d[1], 32'h5);
    chk("relu_l2", cap_d[2], 32'h0);
    chk("relu_l3", cap_d[3], 32'h7FFF_FFFF);
`else
    chk("relu_l0", cap_d[0], 32'hFFFF_FFFF);
    chk("relu_l1", cap_d[1], 32'h5);
    chk("relu_l2", cap_d[2], 32'h8000_0000);
    chk("relu_l3", cap_d[3], 32'h7FFF_FFFF);
`endif
    chk("relu_q_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
